uart_tx: RTL and testbench

Serial transmitter that drains the byte FIFO and drives the host-link UART line. It sits directly downstream of the FIFO read port: it watches the FIFO's read-ready flag, pops one byte with a single-cycle read strobe, and serialises it as an 8N1 frame (optionally 8E1) at a fixed clocks-per-bit rate. It is the last stage before the FPGA's TX pin.

---
 rtl/uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serialises bytes popped from the upstream byte FIFO onto the
// host-link UART line. The frame is 8N1 or 8N2, selected by STOP_BITS.
// Define UART_TX_PARITY_EN to add an even-parity bit, which gives 8E1 or 8E2.
// The serial line and the pop strobe are registered. This keeps the TX pin
// free of glitches.
module uart_tx #(
  parameter int CLOCK_DIV = 12,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       data_ready_i,
  output logic       data_read_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int DIV_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCK_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             read_reg, read_next;
  logic             tx_reg, tx_next;
  logic             bit_end;
  logic             load;

`ifdef UART_TX_PARITY_EN
  // The parity of the incoming byte is computed at pop time.
  // The shift register is empty by the time the parity bit goes out.
  logic       parity_reg, parity_next;
  logic [8:0] par_chain;

  assign par_chain[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ data_i[gi];
    end
  endgenerate
`endif

  // The last cycle of the current bit period.
  assign bit_end = (div_cnt_reg == DIV_LAST);

  // Next-state logic: the bit timing, bit indexing, and fetching the next byte.
  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    read_next    = 1'b0;
    load         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (data_ready_i) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          div_cnt_next = '0;
          bit_cnt_next = 3'd0;
          state_next   = DATA;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_cnt_next = '0;
          shift_next   = {1'b0, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          div_cnt_next = '0;
          bit_cnt_next = 3'd0;
          state_next   = STOP;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          div_cnt_next = '0;
          if (bit_cnt_reg == STOP_LAST) begin
            bit_cnt_next = 3'd0;
            // Chain straight into the next frame when the FIFO has data.
            if (data_ready_i) load = 1'b1;
            else              state_next = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A pop happens only in IDLE or on the final stop cycle.
    // So the strobe can never be high on two consecutive cycles.
    if (load) begin
      shift_next   = data_i;
      read_next    = 1'b1;
      state_next   = START;
      div_cnt_next = '0;
      bit_cnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_next  = par_chain[8];
`endif
    end
  end

  // The line level for the cycle after the edge follows from the next state.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // State and datapath registers. Reset drops any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
      read_reg    <= 1'b0;
      tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      read_reg    <= read_next;
      tx_reg      <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  assign data_read_o = read_reg;
  assign tx_o        = tx_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: two transmitters, one with STOP_BITS=1 and one with STOP_BITS=2,
// both at CLOCK_DIV=4. Each is fed from its own byte queue. The reference
// model tracks the position inside the frame for each instance. It derives
// the expected line level from position/CLOCK_DIV and the frame bit layout.
module tb_uart_tx;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] data_i       [2];
  logic       data_ready_i [2];
  logic       data_read_o  [2];
  logic       tx_o         [2];
  logic       busy_o       [2];

  uart_tx #(.CLOCK_DIV(DIV), .STOP_BITS(1)) dut0 (
    .clock(clock), .reset(reset),
    .data_i(data_i[0]), .data_ready_i(data_ready_i[0]),
    .data_read_o(data_read_o[0]), .tx_o(tx_o[0]), .busy_o(busy_o[0])
  );

  uart_tx #(.CLOCK_DIV(DIV), .STOP_BITS(2)) dut1 (
    .clock(clock), .reset(reset),
    .data_i(data_i[1]), .data_ready_i(data_ready_i[1]),
    .data_read_o(data_read_o[1]), .tx_o(tx_o[1]), .busy_o(busy_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         pos   [2];
  logic [7:0] cur   [2];
  int         pulses[2];
  int         pop_t0[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int frame_len(input int k);
    return (1 + 8 + P + (k + 1)) * DIV;
  endfunction

  function automatic logic exp_tx(input int k);
    int b;
    if (pos[k] < 0) return 1'b1;
    b = pos[k] / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[k][b-1];
    if (P == 1 && b == 9) return ^cur[k];
    return 1'b1;
  endfunction

  // The model advances by one clock edge, using the inputs presented before that edge.
  task automatic model_edge(input int k);
    if (reset) begin
      pos[k] = -1;
    end else if (pos[k] < 0 || pos[k] == frame_len(k) - 1) begin
      if (data_ready_i[k]) begin
        pos[k] = 0;
        if (k == 0) cur[k] = q0.pop_front();
        else        cur[k] = q1.pop_front();
      end else begin
        pos[k] = -1;
      end
    end else begin
      pos[k]++;
    end
  endtask

  task automatic check_outputs(input int k);
    chk($sformatf("tx%0d", k),   {31'b0, tx_o[k]},        {31'b0, exp_tx(k)});
    chk($sformatf("busy%0d", k), {31'b0, busy_o[k]},      {31'b0, pos[k] >= 0});
    chk($sformatf("read%0d", k), {31'b0, data_read_o[k]}, {31'b0, pos[k] == 0});
  endtask

  task automatic drive_all();
    data_ready_i[0] = (q0.size() != 0);
    data_i[0]       = (q0.size() != 0) ? q0[0] : 8'($urandom);
    data_ready_i[1] = (q1.size() != 0);
    data_i[1]       = (q1.size() != 0) ? q1[0] : 8'($urandom);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      check_outputs(k);
      if (data_read_o[k]) pulses[k]++;
    end
    if (data_read_o[0]) pop_t0.push_back(cyc);
    drive_all();
  endtask

  initial begin
    pos[0] = -1; pos[1] = -1;
    cur[0] = 8'd0; cur[1] = 8'd0;
    pulses[0] = 0; pulses[1] = 0;
    reset = 1'b1;
    drive_all();

    // Reset values are checked while reset is held. Then reset is released
    // away from a clock edge, with both FIFOs empty.
    repeat (3) step();
    #2 reset = 1'b0;
    repeat (100) step();

    // A single byte 0xA5 gives one pop and a 40-cycle frame.
    pulses[0] = 0;
    q0.push_back(8'hA5);
    drive_all();
    repeat (60) step();
    chk("a5_pops", pulses[0], 1);

    // Three queued bytes are sent back to back.
    pulses[0] = 0;
    pop_t0.delete();
    q0.push_back(8'h00); q0.push_back(8'hFF); q0.push_back(8'h55);
    drive_all();
    repeat (130) step();
    chk("b2b_pops", pulses[0], 3);
    if (pop_t0.size() == 3) begin
      chk("b2b_gap1", pop_t0[1] - pop_t0[0], frame_len(0));
      chk("b2b_gap2", pop_t0[2] - pop_t0[1], frame_len(0));
    end else begin
      chk("b2b_pop_times", pop_t0.size(), 3);
    end

    // Two stop bits with byte 0x01, then a short burst on both instances.
    pulses[1] = 0;
    q1.push_back(8'h01);
    drive_all();
    repeat (60) step();
    chk("stop2_pops", pulses[1], 1);
    q1.push_back(8'($urandom)); q1.push_back(8'($urandom)); q1.push_back(8'($urandom));
    q0.push_back(8'($urandom)); q0.push_back(8'($urandom));
    drive_all();
    repeat (150) step();

    // Random bursts with random gaps, then a drain period.
    pulses[0] = 0; pulses[1] = 0;
    for (int it = 0; it < 8; it++) begin
      int n0, n1;
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      for (int j = 0; j < n0; j++) q0.push_back(8'($urandom));
      for (int j = 0; j < n1; j++) q1.push_back(8'($urandom));
      drive_all();
      repeat (int'($urandom_range(20, 150))) step();
    end
    repeat (300) step();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    // Reset asserted 13 cycles into a frame. The outputs must clear with no clock edge.
    q0.push_back(8'h99); q1.push_back(8'h99);
    drive_all();
    repeat (14) step();
    chk("pre_rst_busy0", {31'b0, busy_o[0]}, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_tx0",   {31'b0, tx_o[0]},        1);
    chk("async_busy0", {31'b0, busy_o[0]},      0);
    chk("async_read0", {31'b0, data_read_o[0]}, 0);
    chk("async_tx1",   {31'b0, tx_o[1]},        1);
    chk("async_busy1", {31'b0, busy_o[1]},      0);
    repeat (2) step();
    #2 reset = 1'b0;
    pulses[0] = 0; pulses[1] = 0;
    q0.push_back(8'h3C);
    drive_all();
    repeat (60) step();
    chk("post_rst_pops0", pulses[0], 1);
    chk("post_rst_pops1", pulses[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
